// File: rtl/immediate_packer_pkg.sv
// Shared definitions for the immediate packer: format codes, slot positions
// and the signed/unsigned immediate range check.
`default_nettype none

package immediate_packer_pkg;

    typedef enum logic [2:0] {
        FMT_U     = 3'b000,
        FMT_J     = 3'b001,
        FMT_I     = 3'b010,
        FMT_B     = 3'b011,
        FMT_S     = 3'b100,
        FMT_SHAMT = 3'b101
    } fmt_e;

    localparam int UNSIGNED_BIT = 3;

    localparam int U_IMM_LSB = 12;
    localparam int I_IMM_LSB = 20;
    localparam int S_HI_LSB  = 25;
    localparam int S_LO_LSB  = 7;
    localparam int SHAMT_LSB = 20;

    // True when imm fits in n bits (two's complement, or plain binary when unsigned).
    function automatic logic range_ok(input logic [31:0] imm, input int n, input logic is_unsigned);
        logic [31:0] hi;
        if (is_unsigned) begin
            hi = imm >> n;
            return (hi == 32'd0);
        end
        hi = $signed(imm) >>> (n - 1);
        return (hi == 32'd0) || (hi == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/immediate_packer_imm_pack_comb.sv
// Pure combinational scatter of a 32-bit immediate into the RV32 slots of the
// selected format, with range/alignment/illegal-select error flag.
`default_nettype none

module imm_pack_comb
    import immediate_packer_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [3:0]  select,
    output logic [31:0] word,
    output logic        err
);

    logic is_unsigned;
    assign is_unsigned = select[UNSIGNED_BIT];

    always_comb begin
        word = base;
        err  = 1'b0;
        case (fmt_e'(select[2:0]))
            FMT_U: begin
                word[31:U_IMM_LSB] = imm[31:12];
                err                = |imm[11:0];
            end
            FMT_J: begin
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
                err         = imm[0] | ~range_ok(imm, 21, is_unsigned);
            end
            FMT_I: begin
                word[31:I_IMM_LSB] = imm[11:0];
                err                = ~range_ok(imm, 12, is_unsigned);
            end
            FMT_B: begin
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
                err         = imm[0] | ~range_ok(imm, 13, is_unsigned);
            end
            FMT_S: begin
                word[31:S_HI_LSB]   = imm[11:5];
                word[11:S_LO_LSB]   = imm[4:0];
                err                 = ~range_ok(imm, 12, is_unsigned);
            end
            FMT_SHAMT: begin
                // Shift amounts are always unsigned; the select's signedness bit is ignored.
                word[24:SHAMT_LSB] = imm[4:0];
                err                = |imm[31:5];
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/immediate_packer.sv
// Streaming immediate packer: registered output stage plus one-entry skid
// buffer around imm_pack_comb, with a saturating count of delivered error words.
`default_nettype none

module immediate_packer
    import immediate_packer_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          base_instr,
    input  logic [31:0]          imm,
    input  logic [3:0]           select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instruction,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [31:0] packed_word;
    logic        packed_err;

    logic        skid_valid;
    logic [31:0] skid_word;
    logic        skid_err;

    logic        accept;
    logic        out_free;

    imm_pack_comb u_pack (
        .base   (base_instr),
        .imm    (imm),
        .select (select),
        .word   (packed_word),
        .err    (packed_err)
    );

    // in_ready comes straight from the skid occupancy flop.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            instruction <= 32'd0;
            error       <= 1'b0;
            skid_valid  <= 1'b0;
            skid_word   <= 32'd0;
            skid_err    <= 1'b0;
        end else if (skid_valid) begin
            if (out_free) begin
                out_valid   <= 1'b1;
                instruction <= skid_word;
                error       <= skid_err;
                skid_valid  <= 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                out_valid   <= 1'b1;
                instruction <= packed_word;
                error       <= packed_err;
            end else begin
                skid_valid  <= 1'b1;
                skid_word   <= packed_word;
                skid_err    <= packed_err;
            end
        end else if (out_free) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_valid && out_ready && error && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_immediate_packer.sv
// Self-checking bench for immediate_packer: directed encodings, randomized
// streaming against a reference model, backpressure, saturation and reset.
`default_nettype none

module tb_immediate_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic [3:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        error;
    logic [7:0]  err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_errcnt = 0;

    immediate_packer #(.ERR_CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .base_instr  (base_instr),
        .imm         (imm),
        .select      (select),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .error       (error),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic bit in_range(input logic [31:0] v, input int n, input bit uns);
        longint s   = longint'($signed(v));
        longint lim = longint'(1) << n;
        if (uns) return longint'(v) < lim;
        return (s >= -(lim / 2)) && (s < lim / 2);
    endfunction

    // Reference: field value built arithmetically, merged into base through a slot mask.
    function automatic void ref_pack(input logic [31:0] base, input logic [31:0] v,
                                     input logic [3:0] sel,
                                     output logic [31:0] word, output logic err);
        logic [31:0] mask;
        logic [31:0] field;
        bit          uns = sel[3];
        mask = 32'd0; field = 32'd0; err = 1'b0;
        case (sel[2:0])
            3'd0: begin
                mask = 32'hFFFFF000; field = v & 32'hFFFFF000; err = (v % 4096) != 0;
            end
            3'd1: begin
                mask  = 32'hFFFFF000;
                field = (((v >> 20) & 1) << 31) | (((v >> 1) % 1024) << 21)
                      | (((v >> 11) & 1) << 20) | (((v >> 12) % 256) << 12);
                err   = v[0] || !in_range(v, 21, uns);
            end
            3'd2: begin
                mask = 32'hFFF00000; field = (v % 4096) << 20; err = !in_range(v, 12, uns);
            end
            3'd3: begin
                mask  = 32'hFE000F80;
                field = (((v >> 12) & 1) << 31) | (((v >> 5) % 64) << 25)
                      | (((v >> 1) % 16) << 8) | (((v >> 11) & 1) << 7);
                err   = v[0] || !in_range(v, 13, uns);
            end
            3'd4: begin
                mask  = 32'hFE000F80;
                field = (((v >> 5) % 128) << 25) | ((v % 32) << 7);
                err   = !in_range(v, 12, uns);
            end
            3'd5: begin
                mask = 32'h01F00000; field = (v % 32) << 20; err = v >= 32;
            end
            default: err = 1'b1;
        endcase
        word = (base & ~mask) | field;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        base_instr = 32'd0; imm = 32'd0; select = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || instruction !== 32'd0 || error !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b instr=%h err=%b cnt=%0d, required 0/0/0/0",
                     out_valid, instruction, error, err_count);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        exp_errcnt = 0;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] v;
        logic [3:0]  sel;
        logic [31:0] word;
        logic        err;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[13];
        tbl[0]  = '{32'h00000093, 32'hFFFFFFFF, 4'b0010, 32'hFFF00093, 1'b0};
        tbl[1]  = '{32'h00000063, 32'hFFFFFFFC, 4'b0011, 32'hFE000EE3, 1'b0};
        tbl[2]  = '{32'h00000063, 32'h00000002, 4'b0011, 32'h00000163, 1'b0};
        tbl[3]  = '{32'h00000063, 32'h00000001, 4'b0011, 32'h00000063, 1'b1};
        tbl[4]  = '{32'h000000B7, 32'h12345000, 4'b0000, 32'h123450B7, 1'b0};
        tbl[5]  = '{32'h000000B7, 32'h12345001, 4'b0000, 32'h123450B7, 1'b1};
        tbl[6]  = '{32'h00000093, 32'h00000800, 4'b0010, 32'h80000093, 1'b1};
        tbl[7]  = '{32'h00000093, 32'h00000800, 4'b1010, 32'h80000093, 1'b0};
        tbl[8]  = '{32'h00001013, 32'h0000001F, 4'b0101, 32'h01F01013, 1'b0};
        tbl[9]  = '{32'h00001013, 32'h00000020, 4'b0101, 32'h00001013, 1'b1};
        tbl[10] = '{32'hDEADBEEF, 32'h12345678, 4'b0110, 32'hDEADBEEF, 1'b1};
        tbl[11] = '{32'h0000006F, 32'h00000800, 4'b0001, 32'h0010006F, 1'b0};
        tbl[12] = '{32'h00002023, 32'hFFFFFFFF, 4'b0100, 32'hFE002FA3, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; base_instr = tbl[i].base; imm = tbl[i].v; select = tbl[i].sel;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d_early: out_valid=%b before accept edge, required 0", i, out_valid);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || instruction !== tbl[i].word || error !== tbl[i].err) begin
                n_fail++;
                $display("FAIL directed_%0d: valid=%b instr=%h err=%b, required 1 %h %b",
                         i, out_valid, instruction, error, tbl[i].word, tbl[i].err);
            end
            if (tbl[i].err) exp_errcnt++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (err_count !== 8'(exp_errcnt)) begin
            n_fail++;
            $display("FAIL directed_err_count: got %0d, required %0d", err_count, exp_errcnt);
        end
    endtask

    // Randomized stream with independent valid/ready throttling; checks order, data and in_ready.
    task automatic run_stream(input string tag, input int n, input int pv, input int pr, input bit all_bad);
        logic [31:0] q_word[$];
        logic        q_err[$];
        logic [31:0] w;
        logic        e;
        int sent = 0, got = 0, occ = 0, cyc = 0;
        bit acc, drn;
        in_valid = 1'b0; out_ready = 1'b0;
        while (got < n && cyc < n * 20 + 100) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== (occ < 2)) begin
                n_fail++;
                $display("FAIL %s_in_ready: cycle %0d got %b with %0d held, required %b",
                         tag, cyc, in_ready, occ, occ < 2);
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                n_cmp++;
                if (q_word.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_spurious: output %h with nothing outstanding", tag, instruction);
                end else begin
                    w = q_word.pop_front();
                    e = q_err.pop_front();
                    if (instruction !== w || error !== e) begin
                        n_fail++;
                        $display("FAIL %s_word_%0d: instr=%h err=%b, required %h %b",
                                 tag, got, instruction, error, w, e);
                    end
                    if (e && exp_errcnt < 255) exp_errcnt++;
                end
                got++;
                occ--;
            end
            if (acc) begin
                ref_pack(base_instr, imm, select, w, e);
                q_word.push_back(w);
                q_err.push_back(e);
                sent++;
                occ++;
            end
            @(posedge clk);
            #1;
            cyc++;
            out_ready = ($urandom_range(0, 99) < pr);
            in_valid  = (sent < n) && ($urandom_range(0, 99) < pv);
            base_instr = $urandom;
            select = all_bad ? {1'($urandom), 3'($urandom_range(6, 7))} : 4'($urandom);
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = $urandom & 32'hFFFFF000;
                default: imm = 32'($urandom_range(0, 40));
            endcase
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s_timeout: received %0d words, required %0d", tag, got, n);
        end
        n_cmp++;
        if (err_count !== 8'(exp_errcnt)) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d, required %0d", tag, err_count, exp_errcnt);
        end
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 8, 100, 50, 1'b0);
    endtask

    task automatic test_random();
        run_stream("random", 400, 70, 60, 1'b0);
    endtask

    task automatic test_saturation();
        run_stream("saturation", 280, 100, 100, 1'b1);
        n_cmp++;
        if (err_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation_hold: got %0d, required 255", err_count);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; base_instr = 32'h00000093; imm = 32'h5; select = 4'b0010;
        @(posedge clk);
        #1 imm = 32'h6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || instruction !== 32'd0 || error !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: valid=%b instr=%h err=%b cnt=%0d, required 0/0/0/0",
                     out_valid, instruction, error, err_count);
        end
        exp_errcnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_stale: %0d stale cycles, in_ready=%b, required 0 and 1", stale, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
